// File: rtl/spi_pwm_cmd_decoder.sv
// spi_pwm_cmd_decoder: oversampled SPI front end that turns 16-bit frames into PWM level write strobes
module spi_pwm_cmd_decoder #(
  parameter int FRAME_BITS  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int NUM_CH      = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       cs,
  input  logic       mosi,
  output logic       miso,
  output logic       pset,
  output logic [2:0] addr,
  output logic [7:0] level,
  output logic       frame_err
);
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  localparam logic [4:0] FULL = 5'(FRAME_BITS);
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic sclk_s, cs_s, mosi_s;
  logic sclk_p_q, cs_p_q, mosi_p_q;
  logic sclk_rise_q, sclk_fall_q, cs_rise_q, cs_fall_q;
  logic [4:0] bit_cnt_q, bit_cnt_d;
  logic [15:0] in_buf_q, in_buf_d;
  logic [7:0] out_buf_q, out_buf_d;
  logic ovf_q, ovf_d;
  logic [3:0] cnt_q, cnt_d;
  logic pset_q, pset_d, frame_err_q, frame_err_d;
  logic [2:0] addr_q, addr_d;
  logic [7:0] level_q, level_d;
  logic complete, good_w, good_r, start;
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_p_q    <= 1'b0;
      cs_p_q      <= 1'b1;
      mosi_p_q    <= 1'b0;
      sclk_rise_q <= 1'b0;
      sclk_fall_q <= 1'b0;
      cs_rise_q   <= 1'b0;
      cs_fall_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_p_q    <= sclk_s;
      cs_p_q      <= cs_s;
      mosi_p_q    <= mosi_s;
      sclk_rise_q <= sclk_s & ~sclk_p_q;
      sclk_fall_q <= ~sclk_s & sclk_p_q;
      cs_rise_q   <= cs_s & ~cs_p_q;
      cs_fall_q   <= ~cs_s & cs_p_q;
    end
  end
  always_comb begin
    complete    = bit_cnt_q == FULL && !ovf_q;
    good_w      = complete && in_buf_q[15] && in_buf_q[14:11] == 4'd0 && 32'(in_buf_q[10:8]) < NUM_CH;
    good_r      = complete && !in_buf_q[15];
    pset_d      = state_q == COMMIT && good_w;
    addr_d      = pset_d ? in_buf_q[10:8] : addr_q;
    level_d     = pset_d ? in_buf_q[7:0] : level_q;
    cnt_d       = cnt_q + {3'd0, pset_d};
    frame_err_d = (state_q != COMMIT || good_r) ? frame_err_q : !good_w;
  end
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    in_buf_d  = in_buf_q;
    out_buf_d = out_buf_q;
    ovf_d     = ovf_q;
    start     = 1'b0;
    case (state_q)
      IDLE: begin
        out_buf_d = '0;
        start     = cs_fall_q;
      end
      SHIFT: begin
        if (cs_rise_q) state_d = COMMIT;
        else begin
          if (sclk_rise_q) begin
            if (bit_cnt_q < FULL) begin
              in_buf_d  = {in_buf_q[14:0], mosi_p_q};
              bit_cnt_d = bit_cnt_q + 5'd1;
            end else ovf_d = 1'b1;
          end
          if (sclk_fall_q) out_buf_d = out_buf_q >> 1;
        end
      end
      default: begin
        state_d   = IDLE;
        out_buf_d = '0;
        start     = !cs_s;
      end
    endcase
    if (start) begin
      state_d   = SHIFT;
      bit_cnt_d = '0;
      in_buf_d  = '0;
      ovf_d     = 1'b0;
      out_buf_d = {frame_err_d, cnt_d, addr_d};
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      in_buf_q    <= '0;
      out_buf_q   <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      pset_q      <= 1'b0;
      addr_q      <= '0;
      level_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      in_buf_q    <= in_buf_d;
      out_buf_q   <= out_buf_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      pset_q      <= pset_d;
      addr_q      <= addr_d;
      level_q     <= level_d;
      frame_err_q <= frame_err_d;
    end
  end
  assign miso      = out_buf_q[0];
  assign pset      = pset_q;
  assign addr      = addr_q;
  assign level     = level_q;
  assign frame_err = frame_err_q;
endmodule
